// File: rtl/mb_booth_pkg.sv
// Shared definitions for the mb32 radix-8 Booth recoder: group count,
// digit-select bit positions and the packed digit-select type.
package mb_booth_pkg;

    // Positions inside a packed digit select {n,q,t,d,s}
    localparam int S = 0;   // |v| == 1
    localparam int D = 1;   // |v| == 2
    localparam int T = 2;   // |v| == 3
    localparam int Q = 3;   // |v| == 4
    localparam int N = 4;   // v < 0

    localparam int DIGIT_W = 5;

    typedef logic [DIGIT_W-1:0] digit_t;

    // Number of radix-8 digit groups produced for a given operand width
    function automatic int group_cnt(input int width);
        return (width >> 2) + 3;
    endfunction

    // Width of the extended multiplier so every group window is in range
    function automatic int xext_w(input int width);
        int need;
        need = 3 * group_cnt(width) + 1;
        return (need > width + 2) ? need : width + 2;
    endfunction

endpackage

// File: rtl/booth8_digit_enc.sv
// Radix-8 Booth digit encoder: one 4-bit overlapping window of the
// extended multiplier in, one-hot magnitude plus sign out.
module booth8_digit_enc
    import mb_booth_pkg::*;
(
    input  logic [3:0] win_i,   // {b3,b2,b1,b0}, b0 overlaps the group below
    output digit_t     dig_o
);

    // Value = -4*b3 + 2*b2 + b1 + b0; zero never carries a sign bit
    always_comb begin
        dig_o = '0;
        unique case (win_i)
            4'b0001, 4'b0010: dig_o[S] = 1'b1;                    // +1
            4'b0011, 4'b0100: dig_o[D] = 1'b1;                    // +2
            4'b0101, 4'b0110: dig_o[T] = 1'b1;                    // +3
            4'b0111:          dig_o[Q] = 1'b1;                    // +4
            4'b1000:          begin dig_o[Q] = 1'b1; dig_o[N] = 1'b1; end  // -4
            4'b1001, 4'b1010: begin dig_o[T] = 1'b1; dig_o[N] = 1'b1; end  // -3
            4'b1011, 4'b1100: begin dig_o[D] = 1'b1; dig_o[N] = 1'b1; end  // -2
            4'b1101, 4'b1110: begin dig_o[S] = 1'b1; dig_o[N] = 1'b1; end  // -1
            default:          dig_o = '0;                         // 0000 / 1111
        endcase
    end

endmodule

// File: rtl/mb32_booth_enc.sv
// Two-stage radix-8 Booth recoder in front of the mb32 multiplier array.
// Stage A captures the raw operands, stage B holds the recoded digit
// selects, the multiplicand and its precomputed triple. Full throughput
// with backpressure; every stage only moves when the one after it frees.
module mb32_booth_enc
    import mb_booth_pkg::*;
#(
    parameter  int WIDTH     = 32,
    localparam int GROUP_CNT = group_cnt(WIDTH)
) (
    input  logic                 CLK,
    input  logic                 RST,        // async, active low

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 is_signed,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [GROUP_CNT-1:0] s,
    output logic [GROUP_CNT-1:0] d,
    output logic [GROUP_CNT-1:0] t,
    output logic [GROUP_CNT-1:0] q,
    output logic [GROUP_CNT-1:0] n,
    output logic [WIDTH-1:0]     my,
    output logic [WIDTH+1:0]     tmy
);

    localparam int XE_W = xext_w(WIDTH);

    // ---------------- stage A: raw operands ----------------
    logic             va_q;
    logic [WIDTH-1:0] xa_q;
    logic [WIDTH-1:0] ya_q;
    logic             sa_q;

    // ---------------- stage B: recoded bundle ----------------
    logic                 ov_q;
    logic [GROUP_CNT-1:0] s_q, d_q, t_q, q_q, n_q;
    logic [WIDTH-1:0]     my_q;
    logic [WIDTH+1:0]     tmy_q;

    // ---------------- handshake ----------------
    logic in_fire;   // operand pair enters stage A
    logic adv_a;     // stage A content moves into stage B

    assign adv_a    = va_q && (!ov_q || out_ready);
    assign in_ready = !va_q || !ov_q || out_ready;
    assign in_fire  = in_valid && in_ready;

    // ---------------- recoding datapath (from stage A) ----------------
    logic                 x_ext_bit;
    logic [XE_W-1:0]      x_ext;
    digit_t [GROUP_CNT-1:0] dig_w;
    logic [GROUP_CNT-1:0] s_d, d_d, t_d, q_d, n_d;
    logic [WIDTH+1:0]     y_ext;
    logic [WIDTH+1:0]     tmy_d;

    // Extension bit replicates the sign only for signed operands
    assign x_ext_bit = sa_q & xa_q[WIDTH-1];
    assign x_ext     = {{(XE_W-WIDTH-1){x_ext_bit}}, xa_q, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < GROUP_CNT; gi++) begin : g_grp
            booth8_digit_enc u_enc (
                .win_i (x_ext[3*gi +: 4]),
                .dig_o (dig_w[gi])
            );
            assign s_d[gi] = dig_w[gi][S];
            assign d_d[gi] = dig_w[gi][D];
            assign t_d[gi] = dig_w[gi][T];
            assign q_d[gi] = dig_w[gi][Q];
            assign n_d[gi] = dig_w[gi][N];
        end
    endgenerate

    // Two guard bits hold 3*y exactly for both signed and unsigned y
    assign y_ext = sa_q ? {{2{ya_q[WIDTH-1]}}, ya_q} : {2'b00, ya_q};
    assign tmy_d = (y_ext << 1) + y_ext;

    // Stage A: capture operands on accept, drop valid once they move on
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            va_q <= 1'b0;
            xa_q <= '0;
            ya_q <= '0;
            sa_q <= 1'b0;
        end else if (in_fire) begin
            va_q <= 1'b1;
            xa_q <= x;
            ya_q <= y;
            sa_q <= is_signed;
        end else if (adv_a) begin
            va_q <= 1'b0;
        end
    end

    // Stage B: load recoded bundle when A advances, else drain on out_ready
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ov_q  <= 1'b0;
            s_q   <= '0;
            d_q   <= '0;
            t_q   <= '0;
            q_q   <= '0;
            n_q   <= '0;
            my_q  <= '0;
            tmy_q <= '0;
        end else if (adv_a) begin
            ov_q  <= 1'b1;
            s_q   <= s_d;
            d_q   <= d_d;
            t_q   <= t_d;
            q_q   <= q_d;
            n_q   <= n_d;
            my_q  <= ya_q;
            tmy_q <= tmy_d;
        end else if (out_ready) begin
            ov_q  <= 1'b0;
        end
    end

    assign out_valid = ov_q;
    assign s         = s_q;
    assign d         = d_q;
    assign t         = t_q;
    assign q         = q_q;
    assign n         = n_q;
    assign my        = my_q;
    assign tmy       = tmy_q;

endmodule

// File: tb/tb_mb32_booth_enc.sv
// Bench for mb32_booth_enc: directed vector table, throughput burst,
// randomized stream under backpressure, and reset with both stages full.
module tb_mb32_booth_enc;
    import mb_booth_pkg::*;

    localparam int W  = 32;
    localparam int GC = group_cnt(W);

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  x, y, my;
    logic          is_signed;
    logic [GC-1:0] s, d, t, q, n;
    logic [W+1:0]  tmy;

    mb32_booth_enc #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .d(d), .t(t), .q(q), .n(n),
        .my(my), .tmy(tmy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0]  x, y;
        logic          sg;
        logic [GC-1:0] s, d, t, q, n;
        logic [W+1:0]  tmy;
    } exp_t;

    typedef struct {
        string         name;
        logic [W-1:0]  x, y;
        logic          sg;
        logic [GC-1:0] s, d, t, q, n;
        logic [W+1:0]  tmy;
    } vec_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   saw_full = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference recoding by direct digit arithmetic on the extended multiplier
    function automatic exp_t model(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic sg);
        exp_t   e;
        logic   ext;
        longint yl, tl;
        e.x = xv; e.y = yv; e.sg = sg;
        e.s = '0; e.d = '0; e.t = '0; e.q = '0; e.n = '0;
        ext = sg & xv[W-1];
        for (int i = 0; i < GC; i++) begin
            logic [3:0] b;
            int v, m;
            for (int j = 0; j < 4; j++) begin
                int k;
                k = 3*i + j;
                b[j] = (k == 0) ? 1'b0 : (k <= W) ? xv[k-1] : ext;
            end
            v = 2*int'(b[2]) + int'(b[1]) + int'(b[0]) - 4*int'(b[3]);
            m = (v < 0) ? -v : v;
            if (m == 1) e.s[i] = 1'b1;
            if (m == 2) e.d[i] = 1'b1;
            if (m == 3) e.t[i] = 1'b1;
            if (m == 4) e.q[i] = 1'b1;
            e.n[i] = (v < 0);
        end
        yl = sg ? longint'(signed'(yv)) : longint'(yv);
        tl = 3 * yl;
        e.tmy = tl[W+1:0];
        return e;
    endfunction

    // Rebuild x from the DUT's digit selects: sum of v_i * 8^i
    function automatic longint recon();
        longint acc = 0;
        for (int i = 0; i < GC; i++) begin
            longint m;
            m = s[i] ? 1 : d[i] ? 2 : t[i] ? 3 : q[i] ? 4 : 0;
            if (n[i]) acc = acc - (m <<< (3*i));
            else      acc = acc + (m <<< (3*i));
        end
        return acc;
    endfunction

    // Scoreboard monitor: inputs and outputs sampled on the falling edge
    logic          held = 1'b0;
    logic [5*GC-1:0] hold_dig;
    logic [W-1:0]  hold_my;
    logic [W+1:0]  hold_tmy;
    int            occ;
    exp_t          e;
    longint        xe;

    always @(negedge CLK) begin
        if (!RST) begin
            held = 1'b0;
        end else begin
            occ = sbq.size();
            if (occ == 2 && !out_ready) saw_full++;
            chk("in_ready", in_ready, (occ == 2 && !out_ready) ? 1'b0 : 1'b1);
            if (held) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_dig", {s, d, t, q, n}, hold_dig);
                chk("hold_my", my, hold_my);
                chk("hold_tmy", tmy, hold_tmy);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", 1'b1, 1'b0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_s", s, e.s);
                    chk("sb_d", d, e.d);
                    chk("sb_t", t, e.t);
                    chk("sb_q", q, e.q);
                    chk("sb_n", n, e.n);
                    chk("sb_my", my, e.y);
                    chk("sb_tmy", tmy, e.tmy);
                    xe = e.sg ? longint'(signed'(e.x)) : longint'(e.x);
                    chk("sb_recon", recon(), xe);
                end
            end
            held     = out_valid && !out_ready;
            hold_dig = {s, d, t, q, n};
            hold_my  = my;
            hold_tmy = tmy;
            if (in_valid && in_ready) sbq.push_back(model(x, y, is_signed));
        end
    end

    // Drive one operand pair, return number of cycles until accepted
    task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic sg, output int cyc);
        logic acc;
        cyc = 0;
        in_valid = 1'b1; x = xv; y = yv; is_signed = sg;
        do begin
            @(negedge CLK); acc = in_ready;
            @(posedge CLK); #1;
            cyc++;
        end while (!acc && cyc < 50);
        if (!acc) chk("accept_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int g = 0; g < 60 && sbq.size() != 0; g++) @(posedge CLK);
        #1;
        chk("drain", sbq.size(), 0);
    endtask

    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        tbl[0]  = '{"x3_y5_u",  32'd3,        32'd5,        1'b0, 11'h000, 11'h000, 11'h001, 11'h000, 11'h000, 34'd15};
        tbl[1]  = '{"x4_u",     32'd4,        32'd0,        1'b0, 11'h002, 11'h000, 11'h000, 11'h001, 11'h001, 34'd0};
        tbl[2]  = '{"xff_s",    32'hFFFFFFFF, 32'd0,        1'b1, 11'h001, 11'h000, 11'h000, 11'h000, 11'h001, 34'd0};
        tbl[3]  = '{"xff_u",    32'hFFFFFFFF, 32'd0,        1'b0, 11'h001, 11'h000, 11'h000, 11'h400, 11'h001, 34'd0};
        tbl[4]  = '{"y80_s",    32'd0,        32'h80000000, 1'b1, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 34'h2_8000_0000};
        tbl[5]  = '{"yff_u",    32'd0,        32'hFFFFFFFF, 1'b0, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 34'h2_FFFF_FFFD};
        tbl[6]  = '{"yff_s",    32'd0,        32'hFFFFFFFF, 1'b1, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 34'h3_FFFF_FFFD};
        tbl[7]  = '{"x80_s",    32'h80000000, 32'd3,        1'b1, 11'h000, 11'h400, 11'h000, 11'h000, 11'h400, 34'd9};
        tbl[8]  = '{"x80_u",    32'h80000000, 32'd0,        1'b0, 11'h000, 11'h400, 11'h000, 11'h000, 11'h000, 34'd0};
        tbl[9]  = '{"xm8_s",    32'hFFFFFFF8, 32'd0,        1'b1, 11'h002, 11'h000, 11'h000, 11'h000, 11'h002, 34'd0};
        tbl[10] = '{"x1_y7_u",  32'd1,        32'd7,        1'b0, 11'h001, 11'h000, 11'h000, 11'h000, 11'h000, 34'd21};

        in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; is_signed = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_dig", {s, d, t, q, n}, '0);
        chk("rst_my", my, '0);
        chk("rst_tmy", tmy, '0);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Directed vectors with exact two-cycle latency
        foreach (tbl[i]) begin
            send(tbl[i].x, tbl[i].y, tbl[i].sg, cyc);
            @(negedge CLK);
            chk({tbl[i].name, ".early"}, out_valid, 1'b0);
            @(negedge CLK);
            chk({tbl[i].name, ".valid"}, out_valid, 1'b1);
            chk({tbl[i].name, ".s"}, s, tbl[i].s);
            chk({tbl[i].name, ".d"}, d, tbl[i].d);
            chk({tbl[i].name, ".t"}, t, tbl[i].t);
            chk({tbl[i].name, ".q"}, q, tbl[i].q);
            chk({tbl[i].name, ".n"}, n, tbl[i].n);
            chk({tbl[i].name, ".my"}, my, tbl[i].y);
            chk({tbl[i].name, ".tmy"}, tmy, tbl[i].tmy);
            @(posedge CLK); #1;
        end
        drain();

        // Back-to-back burst: one accept per cycle with out_ready held high
        for (int i = 0; i < 6; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), cyc);
            chk("tput_cycles", cyc, 1);
        end
        drain();

        // Random stream with out_ready pattern 1,0,0 repeating
        fork
            begin
                for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), cyc);
            end
            begin
                for (int c = 0; c < 45; c++) begin
                    out_ready = (c % 3 == 0);
                    @(posedge CLK); #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("saw_backpressure", (saw_full > 0), 1'b1);

        // Reset with both stages full
        out_ready = 1'b0;
        send(32'h12345678, 32'd11, 1'b0, cyc);
        send(32'h0BADF00D, 32'd22, 1'b1, cyc);
        chk("full_valid", out_valid, 1'b1);
        chk("full_in_ready", in_ready, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        sbq.delete();
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_dig", {s, d, t, q, n}, '0);
        chk("midrst_my", my, '0);
        chk("midrst_tmy", tmy, '0);
        @(posedge CLK); #1;
        RST = 1'b1;
        out_ready = 1'b1;
        @(posedge CLK); #1;
        send(32'd1, 32'd0, 1'b0, cyc);
        @(negedge CLK);
        chk("post_rst_early", out_valid, 1'b0);
        @(negedge CLK);
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_s", s, 11'h001);
        chk("post_rst_dqtn", {d, t, q, n}, '0);
        @(posedge CLK); #1;
        drain();
        repeat (3) @(posedge CLK);
        #1;
        chk("post_rst_idle", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
